// File: rtl/dmem_pkg.sv
// Shared widths, state types and helper functions for the dual-port data memory.
package dmem_pkg;

   // Upper bounds for the generic helpers; instances are checked against these.
   localparam int unsigned MAX_ADDR_W = 64;
   localparam int unsigned MAX_DATA_W = 256;
   localparam int unsigned MAX_NB     = MAX_DATA_W / 8;

   // Response slot occupancy.
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   // Number of byte lanes in a word.
   function automatic int unsigned calc_nb(input int unsigned data_w);
      return data_w / 8;
   endfunction

   // Byte-offset bits below the word index.
   function automatic int unsigned calc_off_w(input int unsigned data_w);
      return 32'($clog2(data_w / 8));
   endfunction

   // Word-index bits for a given depth.
   function automatic int unsigned calc_idx_w(input int unsigned depth);
      return 32'($clog2(depth));
   endfunction

   // True when no address bit at or above used_w is set.
   function automatic logic addr_in_range(input logic [MAX_ADDR_W-1:0] addr,
                                          input int unsigned           used_w);
      return (addr >> used_w) == '0;
   endfunction

   // Replace the strobed byte lanes of old_word with those of new_word.
   function automatic logic [MAX_DATA_W-1:0] byte_merge(input logic [MAX_DATA_W-1:0] old_word,
                                                        input logic [MAX_DATA_W-1:0] new_word,
                                                        input logic [MAX_NB-1:0]     strb);
      logic [MAX_DATA_W-1:0] res;
      res = old_word;
      for (int unsigned i = 0; i < MAX_NB; i++) begin
         if (strb[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dmem_rsp_slot.sv
// One-entry response register with valid/ready handshake on both sides.
// The payload only changes on an accepted push, so it is stable while held.
module dmem_rsp_slot
   import dmem_pkg::*;
#(
   parameter int unsigned W = 33
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready_c,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   slot_state_e  state_q;
   slot_state_e  state_d;
   logic [W-1:0] data_d;
   logic         accept;

   // A push is possible when empty or when the held entry leaves this cycle.
   assign in_ready_c = (state_q == SLOT_EMPTY) || out_ready;
   assign accept     = in_valid && in_ready_c;
   assign out_valid  = (state_q == SLOT_FULL);

   // State and payload registers; synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= SLOT_EMPTY;
         out_data <= '0;
      end else begin
         state_q  <= state_d;
         out_data <= data_d;
      end
   end

   // Next-state and payload selection.
   always_comb begin
      state_d = state_q;
      data_d  = out_data;
      case (state_q)
         SLOT_EMPTY: begin
            if (accept) begin
               state_d = SLOT_FULL;
               data_d  = in_data;
            end
         end
         SLOT_FULL: begin
            if (accept) begin
               data_d = in_data;
            end else if (out_ready) begin
               state_d = SLOT_EMPTY;
            end
         end
         default: state_d = SLOT_EMPTY;
      endcase
   end

endmodule

// File: rtl/dual_port_data_mem.sv
// Byte-writable true dual-port data memory: port A is the CPU load/store port
// with fixed 1-cycle latency, port B is a valid/ready request port with a
// one-entry buffered response. Both ports read the word before any same-cycle
// write; on a same-word write collision port A owns the lanes it strobes.
module dual_port_data_mem
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned ADDR_W    = 32,
   parameter string       INIT_FILE = ""
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_en,
   input  logic [DATA_W/8-1:0]   a_we,
   input  logic [ADDR_W-1:0]     a_addr,
   input  logic [DATA_W-1:0]     a_wdata,
   output logic [DATA_W-1:0]     a_rdata,
   output logic                  a_err,
   input  logic                  b_req_valid,
   output logic                  b_req_ready,
   input  logic [DATA_W/8-1:0]   b_we,
   input  logic [ADDR_W-1:0]     b_addr,
   input  logic [DATA_W-1:0]     b_wdata,
   output logic                  b_rsp_valid,
   input  logic                  b_rsp_ready,
   output logic [DATA_W-1:0]     b_rsp_rdata,
   output logic                  b_rsp_err
);

   localparam int unsigned NB     = calc_nb(DATA_W);
   localparam int unsigned OFF_W  = calc_off_w(DATA_W);
   localparam int unsigned IDX_W  = calc_idx_w(DEPTH);
   localparam int unsigned USED_W = OFF_W + IDX_W;
   localparam int unsigned RSP_W  = DATA_W + 1;

   // Elaboration-time parameter sanity.
   if (DATA_W == 0 || DATA_W % 8 != 0 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
      $error("dual_port_data_mem: DATA_W must be a non-zero multiple of 8 up to %0d", MAX_DATA_W);
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("dual_port_data_mem: DEPTH must be a power of 2, at least 2");
   end
   if (ADDR_W < USED_W || ADDR_W > MAX_ADDR_W) begin : g_bad_addr_w
      $error("dual_port_data_mem: ADDR_W must cover the word index and be at most %0d", MAX_ADDR_W);
   end
   if (INIT_FILE != "") begin : g_init_note
      $info("dual_port_data_mem: INIT_FILE image is applied by the memory implementation flow");
   end

   logic [DATA_W-1:0] mem [DEPTH];

   logic [IDX_W-1:0]  a_idx;
   logic [IDX_W-1:0]  b_idx;
   logic              a_ok;
   logic              b_ok;
   logic              run_q;
   logic              slot_ready_c;
   logic              b_acc;
   logic              a_wr;
   logic              b_wr;
   logic              collide;
   logic [NB-1:0]     b_strb_eff;
   logic [DATA_W-1:0] b_data_eff;
   logic [DATA_W-1:0] b_rd;
   logic [RSP_W-1:0]  rsp_in;
   logic [RSP_W-1:0]  rsp_out;

   // Address decode and range check for both ports.
   assign a_idx = a_addr[USED_W-1:OFF_W];
   assign b_idx = b_addr[USED_W-1:OFF_W];
   assign a_ok  = addr_in_range(MAX_ADDR_W'(a_addr), USED_W);
   assign b_ok  = addr_in_range(MAX_ADDR_W'(b_addr), USED_W);

   // Request side is held off during reset and opens the cycle after release.
   assign b_req_ready = run_q && slot_ready_c;
   assign b_acc       = b_req_valid && b_req_ready;

   // Tracks that the block has left reset.
   always_ff @(posedge clk) begin
      if (!rst) run_q <= 1'b0;
      else      run_q <= 1'b1;
   end

   // Write enables and collision folding: on a same-word clash A's lanes are
   // merged into B's write so a single port writes the word.
   always_comb begin
      a_wr       = 1'b0;
      b_wr       = 1'b0;
      collide    = 1'b0;
      b_strb_eff = b_we;
      b_data_eff = b_wdata;
      a_wr       = rst && a_en && a_ok && (|a_we);
      b_wr       = rst && b_acc && b_ok && (|b_we);
      collide    = a_wr && b_wr && (a_idx == b_idx);
      if (collide) begin
         b_strb_eff = b_we | a_we;
         b_data_eff = DATA_W'(byte_merge(MAX_DATA_W'(b_wdata), MAX_DATA_W'(a_wdata),
                                         MAX_NB'(a_we)));
      end
   end

   // Byte-lane writes for both ports.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NB; i++) begin
         if (a_wr && !collide && a_we[i]) mem[a_idx][i*8 +: 8] <= a_wdata[i*8 +: 8];
         if (b_wr && b_strb_eff[i])       mem[b_idx][i*8 +: 8] <= b_data_eff[i*8 +: 8];
      end
   end

   // Port A read register; holds its value when the port is idle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         a_rdata <= '0;
         a_err   <= 1'b0;
      end else if (a_en) begin
         a_rdata <= a_ok ? mem[a_idx] : '0;
         a_err   <= !a_ok;
      end
   end

   // Port B response payload: old word for in-range reads, zero otherwise.
   assign b_rd   = (b_ok && !(|b_we)) ? mem[b_idx] : '0;
   assign rsp_in = {b_rd, !b_ok};

   dmem_rsp_slot #(
      .W (RSP_W)
   ) u_rsp_slot (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (b_req_valid && run_q),
      .in_ready_c (slot_ready_c),
      .in_data    (rsp_in),
      .out_valid  (b_rsp_valid),
      .out_ready  (b_rsp_ready),
      .out_data   (rsp_out)
   );

   assign b_rsp_rdata = rsp_out[RSP_W-1:1];
   assign b_rsp_err   = rsp_out[0];

endmodule

// File: tb/tb_dual_port_data_mem.sv
// Randomised bench for dual_port_data_mem with a word-array reference model.
module tb_dual_port_data_mem;

   typedef struct packed {
      logic [31:0] d;
      logic        e;
   } rsp_t;

   logic        clk;
   logic        rst;
   logic        a_en;
   logic [3:0]  a_we;
   logic [31:0] a_addr;
   logic [31:0] a_wdata;
   logic [31:0] a_rdata;
   logic        a_err;
   logic        b_req_valid;
   logic        b_req_ready;
   logic [3:0]  b_we;
   logic [31:0] b_addr;
   logic [31:0] b_wdata;
   logic        b_rsp_valid;
   logic        b_rsp_ready;
   logic [31:0] b_rsp_rdata;
   logic        b_rsp_err;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_m [1024];
   logic [31:0] exp_a    = '0;
   logic        exp_aerr = 1'b0;
   rsp_t        rsp_q[$];
   logic [31:0] got_q[$];
   bit          run_m  = 1'b0;
   bit          primed = 1'b0;

   dual_port_data_mem dut (
      .clk         (clk),
      .rst         (rst),
      .a_en        (a_en),
      .a_we        (a_we),
      .a_addr      (a_addr),
      .a_wdata     (a_wdata),
      .a_rdata     (a_rdata),
      .a_err       (a_err),
      .b_req_valid (b_req_valid),
      .b_req_ready (b_req_ready),
      .b_we        (b_we),
      .b_addr      (b_addr),
      .b_wdata     (b_wdata),
      .b_rsp_valid (b_rsp_valid),
      .b_rsp_ready (b_rsp_ready),
      .b_rsp_rdata (b_rsp_rdata),
      .b_rsp_err   (b_rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic bit in_rng(input logic [31:0] a);
      return a < 32'h1000;
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a % 32'h1000) / 4);
   endfunction

   function automatic logic [31:0] lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] we);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

   // One clock cycle: drive at negedge, model the edge, compare at next negedge.
   task automatic step(input bit r, input bit ae, input logic [3:0] awe, input logic [31:0] aad,
                       input logic [31:0] awd, input bit bv, input logic [3:0] bwe,
                       input logic [31:0] bad, input logic [31:0] bwd, input bit brr,
                       output bit acc);
      bit   exp_rdy;
      rsp_t nr;
      rst = r; a_en = ae; a_we = awe; a_addr = aad; a_wdata = awd;
      b_req_valid = bv; b_we = bwe; b_addr = bad; b_wdata = bwd; b_rsp_ready = brr;
      #1;
      exp_rdy = run_m && (rsp_q.size() == 0 || brr);
      if (primed) chk("b_req_ready", 64'(b_req_ready), 64'(exp_rdy));
      acc = r && bv && exp_rdy;
      if (r && brr && b_rsp_valid) got_q.push_back(b_rsp_rdata);
      @(posedge clk);
      if (!r) begin
         exp_a = '0; exp_aerr = 1'b0; rsp_q.delete(); run_m = 1'b0;
      end else begin
         if (rsp_q.size() > 0 && brr) rsp_q.delete(0);
         if (acc) begin
            nr.e = !in_rng(bad);
            nr.d = (in_rng(bad) && bwe == 4'd0) ? mem_m[widx(bad)] : 32'd0;
            rsp_q.push_back(nr);
         end
         if (ae) begin
            exp_aerr = !in_rng(aad);
            exp_a    = in_rng(aad) ? mem_m[widx(aad)] : 32'd0;
         end
         if (acc && in_rng(bad)) mem_m[widx(bad)] = lanes(mem_m[widx(bad)], bwd, bwe);
         if (ae && in_rng(aad))  mem_m[widx(aad)] = lanes(mem_m[widx(aad)], awd, awe);
         run_m = 1'b1;
      end
      primed = 1'b1;
      @(negedge clk);
      chk("a_rdata", 64'(a_rdata), 64'(exp_a));
      chk("a_err", 64'(a_err), 64'(exp_aerr));
      chk("b_rsp_valid", 64'(b_rsp_valid), 64'(rsp_q.size() > 0));
      if (rsp_q.size() > 0) begin
         chk("b_rsp_rdata", 64'(b_rsp_rdata), 64'(rsp_q[0].d));
         chk("b_rsp_err", 64'(b_rsp_err), 64'(rsp_q[0].e));
      end else if (!r) begin
         chk("rst_b_rsp_rdata", 64'(b_rsp_rdata), 64'd0);
         chk("rst_b_rsp_err", 64'(b_rsp_err), 64'd0);
      end
   endtask

   task automatic a_op(input logic [3:0] we, input logic [31:0] ad, input logic [31:0] wd);
      bit acc;
      step(1'b1, 1'b1, we, ad, wd, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, acc);
   endtask

   task automatic idle(input bit r);
      bit acc;
      step(r, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, acc);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(12, 31));
      return a;
   endfunction

   initial begin
      bit          acc;
      int          k;
      logic [31:0] pa [3];
      logic [31:0] ra;
      logic [31:0] rb;

      rst = 1'b0; a_en = 1'b0; a_we = '0; a_addr = '0; a_wdata = '0;
      b_req_valid = 1'b0; b_we = '0; b_addr = '0; b_wdata = '0; b_rsp_ready = 1'b0;
      @(negedge clk);

      // Reset for two cycles, then release.
      idle(1'b0);
      idle(1'b0);
      chk("reset_ready_low", 64'(b_req_ready), 64'd0);
      chk("reset_a_rdata", 64'(a_rdata), 64'd0);
      chk("reset_rsp_valid", 64'(b_rsp_valid), 64'd0);
      idle(1'b1);
      chk("ready_after_release", 64'(b_req_ready), 64'd1);

      // Prefill the working window of 32 words.
      for (int w = 0; w < 32; w++) a_op(4'hF, 32'(w * 4), $urandom());

      // Byte write on A.
      a_op(4'hF, 32'h70, 32'hDEADBEEF);
      a_op(4'h1, 32'h70, 32'h000000AA);
      a_op(4'h0, 32'h70, 32'h0);
      chk("byte_write_read", 64'(a_rdata), 64'h00000000DEADBEAA);

      // Read-first: B reads while A writes the same word.
      a_op(4'hF, 32'h10, 32'h11111111);
      step(1'b1, 1'b1, 4'hF, 32'h10, 32'h22222222, 1'b1, 4'h0, 32'h10, 32'h0, 1'b1, acc);
      chk("read_first_b", 64'(b_rsp_rdata), 64'h11111111);
      a_op(4'h0, 32'h10, 32'h0);
      chk("read_first_a_after", 64'(a_rdata), 64'h22222222);

      // Collision on word 0x40.
      step(1'b1, 1'b1, 4'hC, 32'h40, 32'hAAAA0000, 1'b1, 4'hF, 32'h40, 32'h0000BBBB, 1'b1, acc);
      chk("collision_b_rsp", 64'(b_rsp_rdata), 64'd0);
      idle(1'b1);
      a_op(4'h0, 32'h40, 32'h0);
      chk("collision_word", 64'(a_rdata), 64'h00000000AAAABBBB);

      // Backpressure: three B reads, response side stalled after the first.
      pa[0] = 32'h70; pa[1] = 32'h10; pa[2] = 32'h40;
      k = 0;
      got_q.delete();
      for (int c = 0; c < 12; c++) begin
         step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, k < 3, 4'd0, pa[k % 3], 32'd0,
              (c == 0) || (c >= 4), acc);
         if (acc) k++;
         if (c >= 1 && c <= 3) begin
            chk("bp_ready_low", 64'(b_req_ready), 64'd0);
            chk("bp_held_rdata", 64'(b_rsp_rdata), 64'h00000000DEADBEAA);
         end
      end
      chk("bp_accepted", 64'(k), 64'd3);
      chk("bp_delivered", 64'(got_q.size()), 64'd3);
      if (got_q.size() == 3) begin
         chk("bp_rsp0", 64'(got_q[0]), 64'h00000000DEADBEAA);
         chk("bp_rsp1", 64'(got_q[1]), 64'h0000000022222222);
         chk("bp_rsp2", 64'(got_q[2]), 64'h00000000AAAABBBB);
      end

      // Out-of-range accesses.
      a_op(4'hF, 32'h0, 32'h0BADF00D);
      a_op(4'h0, 32'h1000, 32'h0);
      chk("range_a_err", 64'(a_err), 64'd1);
      chk("range_a_rdata", 64'(a_rdata), 64'd0);
      step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'hF, 32'h1000, 32'h12345678, 1'b1, acc);
      chk("range_b_err", 64'(b_rsp_err), 64'd1);
      a_op(4'h0, 32'h0, 32'h0);
      chk("range_word0_kept", 64'(a_rdata), 64'h000000000BADF00D);

      // Randomised traffic with occasional reset.
      for (int n = 0; n < 3000; n++) begin
         ra = rand_addr();
         rb = ($urandom_range(0, 3) == 0) ? ra : rand_addr();
         step($urandom_range(0, 299) != 0,
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) != 0 ? 4'($urandom()) : 4'd0,
              ra, $urandom(),
              $urandom_range(0, 2) != 0,
              $urandom_range(0, 1) != 0 ? 4'($urandom()) : 4'd0,
              rb, $urandom(),
              $urandom_range(0, 9) < 7,
              acc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
